// File: rtl/flasher_ctrl.sv
// rtl/flasher_ctrl.sv - sequencing controller for the 16-LED bound flasher
//
// Conditions the raw flick button (2-FF sync + debounce), paces the flasher
// with a one-cycle step tick, holds flick until a tick delivers it, and tracks
// the LED bar to report busy/done and count completed runs.
//
// Optional build macro: FLASHER_CTRL_AUTORESTART_EN
//   defined   - button held at run completion re-arms flick automatically
//   undefined - every run needs a fresh press
//
// Ports:
//   clk        system clock, posedge
//   rst        asynchronous active-low reset
//   btn_in     raw asynchronous flick button
//   enable     global run enable, low freezes the prescaler
//   led_state  flasher LED bar (monitored)
//   step_en    one-cycle step tick to the flasher
//   flick_out  held flick level to the flasher
//   busy       run in progress
//   done       one-cycle pulse on run completion
//   run_count  completed runs, saturating
module flasher_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int PRESCALE   = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
    input  logic             enable,
    input  logic [15:0]      led_state,
    output logic             step_en,
    output logic             flick_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] run_count
);

    localparam int PS_W = $clog2(PRESCALE);
    localparam int DB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, RUN, PEAK} state_t;

    logic            btn_meta;
    logic            btn_s;
    logic            btn_db;
    logic            btn_db_q;
    logic [DB_W-1:0] db_cnt;
    logic [PS_W-1:0] ps_cnt;
    logic            press;
    logic            complete;
    logic            restart;
    state_t          state;
    state_t          state_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= btn_in;
            btn_s    <= btn_meta;
        end
    end

    // The update fires on the DEB_CYCLES-th consecutive differing sample,
    // so a new level is accepted after exactly DEB_CYCLES stable samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt   <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            btn_db_q <= btn_db;
            if (btn_s != btn_db) begin
                if (db_cnt == DB_LAST) begin
                    btn_db <= btn_s;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign press = btn_db & ~btn_db_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_cnt <= '0;
        end else if (enable) begin
            ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + 1'b1;
        end
    end

    assign step_en = enable && (ps_cnt == PS_LAST);

    always_comb begin
        state_nxt = state;
        complete  = 1'b0;
        case (state)
            IDLE: if (step_en && flick_out && (led_state == 16'h0000)) state_nxt = RUN;
            RUN:  if (step_en && led_state[15]) state_nxt = PEAK;
            PEAK: begin
                // All-off only counts as completion after the bar has peaked.
                if (step_en && (led_state == 16'h0000)) begin
                    state_nxt = IDLE;
                    complete  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef FLASHER_CTRL_AUTORESTART_EN
    assign restart = complete & btn_db;
`else
    assign restart = 1'b0;
`endif

    // flick_out is the pending-flick register itself. A press coinciding
    // with a tick wins, so that press is held for the following step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flick_out <= 1'b0;
        end else begin
            flick_out <= press | restart | (flick_out & ~step_en);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            run_count <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= complete;
            if (complete && (run_count != CNT_MAX)) begin
                run_count <= run_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flasher_ctrl.sv
// tb/tb_flasher_ctrl.sv - self-checking bench for flasher_ctrl
module tb_flasher_ctrl;

    localparam int DEB = 4;
    localparam int PS  = 8;
    localparam int CW  = 8;
`ifdef FLASHER_CTRL_AUTORESTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          btn_in = 1'b0;
    logic          enable = 1'b0;
    logic [15:0]   led_state = 16'h0000;
    logic          step_en;
    logic          flick_out;
    logic          busy;
    logic          done;
    logic [CW-1:0] run_count;

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct {
        logic [15:0] led;
        logic        busy;
        logic        done;
        logic [7:0]  cnt;
        logic        flick;
    } row_t;
    row_t tbl[7];

    // reference model state
    bit m_sync1, m_btn_s, m_db, m_db_prev, m_pend, m_busy, m_peak, m_done;
    int m_run, m_en, m_count;

    always #5 clk = ~clk;

    flasher_ctrl #(.DEB_CYCLES(DEB), .PRESCALE(PS), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .enable(enable),
        .led_state(led_state), .step_en(step_en), .flick_out(flick_out),
        .busy(busy), .done(done), .run_count(run_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; btn_in = 1'b0; led_state = 16'h0000; enable = 1'b1;
        #1;
        check("rst_step_en", step_en, 0);
        check("rst_flick", flick_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", run_count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_tick(input string name);
        for (int k = 0; k < 64 && !step_en; k++) @(negedge clk);
        if (!step_en) check(name, 0, 1);
    endtask

    task automatic do_step(input logic [15:0] led);
        wait_tick("step_timeout");
        led_state = led;
        @(negedge clk);
    endtask

    task automatic do_press(input bit hold);
        repeat (8) @(negedge clk);
        btn_in = 1'b1;
        for (int k = 0; k < 40 && !flick_out; k++) @(negedge clk);
        if (!flick_out) check("press_timeout", 0, 1);
        if (!hold) btn_in = 1'b0;
    endtask

    initial begin
        int deliveries;
        int hold;
        int r;
        bit tick, press, complete, start;

        // step_en cadence and enable freeze (cycles 11..15 disabled)
        apply_reset();
        for (int c = 1; c <= 40; c++) begin
            enable = !(c >= 11 && c <= 15);
            #1;
            check($sformatf("tick_c%0d", c), step_en, (c == 8 || c == 21 || c == 29 || c == 37));
            @(negedge clk);
        end
        enable = 1'b1;

        // glitch rejection and clean-press latency
        apply_reset();
        btn_in = 1'b1;
        repeat (3) @(negedge clk);
        btn_in = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("glitch_flick", flick_out, 0);
        end
        btn_in = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("press_lat_%0d", k), flick_out, (k == 7));
        end
        wait_tick("t2_tick_timeout");
        check("t2_flick_at_tick", flick_out, 1);
        @(negedge clk);
        check("t2_flick_after_tick", flick_out, 0);
        btn_in = 1'b0;

        // press landing on a tick cycle
        apply_reset();
        wait_tick("t3_align_timeout");
        repeat (2) @(negedge clk);
        btn_in = 1'b1;
        repeat (6) @(negedge clk);
        check("t3_tick_aligned", step_en, 1);
        check("t3_flick_pre", flick_out, 0);
        deliveries = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (step_en && flick_out) deliveries++;
            if (c == 7) check("t3_flick_held", flick_out, 1);
            if (c == 8) check("t3_flick_fell", flick_out, 0);
        end
        check("t3_deliveries", deliveries, 1);
        btn_in = 1'b0;

        // LED sequence table
        tbl[0] = '{16'h0000, 1'b1, 1'b0, 8'd0, 1'b0};
        tbl[1] = '{16'h003F, 1'b1, 1'b0, 8'd0, 1'b0};
        tbl[2] = '{16'h0000, 1'b1, 1'b0, 8'd0, 1'b0};
        tbl[3] = '{16'h07FF, 1'b1, 1'b0, 8'd0, 1'b0};
        tbl[4] = '{16'h001F, 1'b1, 1'b0, 8'd0, 1'b0};
        tbl[5] = '{16'hFFFF, 1'b1, 1'b0, 8'd0, 1'b0};
        tbl[6] = '{16'h0000, 1'b0, 1'b1, 8'd1, 1'b0};
        apply_reset();
        do_press(1'b0);
        for (int i = 0; i < 7; i++) begin
            do_step(tbl[i].led);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            check($sformatf("tbl%0d_done", i), done, tbl[i].done);
            check($sformatf("tbl%0d_count", i), run_count, tbl[i].cnt);
            check($sformatf("tbl%0d_flick", i), flick_out, tbl[i].flick);
        end
        @(negedge clk);
        check("tbl_done_width", done, 0);

        // reset while in PEAK
        do_press(1'b0);
        do_step(16'h0000);
        do_step(16'h8000);
        check("peak_busy", busy, 1);
        apply_reset();
        do_step(16'h0000);
        check("post_rst_done", done, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_count", run_count, 0);

        // randomized run against the reference model
        apply_reset();
        m_sync1 = 0; m_btn_s = 0; m_db = 0; m_db_prev = 0; m_pend = 0;
        m_busy = 0; m_peak = 0; m_done = 0; m_run = 0; m_en = 0; m_count = 0;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                btn_in = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 12);
            end
            hold--;
            enable = ($urandom_range(0, 7) != 0);
            r = $urandom_range(0, 9);
            led_state = (r < 4) ? 16'h0000 : (r < 6) ? 16'h8000 : 16'($urandom);
            #1;
            tick = enable && ((m_en % PS) == PS - 1);
            check("rnd_step_en", step_en, tick);
            check("rnd_flick", flick_out, m_pend);
            check("rnd_busy", busy, m_busy);
            check("rnd_done", done, m_done);
            check("rnd_count", run_count, m_count);
            @(posedge clk);
            press    = m_db && !m_db_prev;
            complete = tick && m_busy && m_peak && (led_state == 16'h0000);
            start    = tick && !m_busy && m_pend && (led_state == 16'h0000);
            m_pend   = press || (m_pend && !tick) || (AUTO && complete && m_db);
            if (start) begin m_busy = 1; m_peak = 0; end
            else if (tick && m_busy && !m_peak && led_state[15]) m_peak = 1;
            else if (complete) begin m_busy = 0; m_peak = 0; end
            m_done = complete;
            if (complete && m_count < 255) m_count++;
            m_db_prev = m_db;
            if (m_btn_s != m_db) begin
                m_run++;
                if (m_run == DEB) begin m_db = m_btn_s; m_run = 0; end
            end else m_run = 0;
            m_btn_s = m_sync1;
            m_sync1 = btn_in;
            if (enable) m_en++;
            @(negedge clk);
        end

        // 256 runs: saturation, then held-button completion
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            do_press(1'b0);
            do_step(16'h0000);
            do_step(16'h8000);
            do_step(16'h0000);
            check($sformatf("sat_done_%0d", i), done, 1);
            check($sformatf("sat_count_%0d", i), run_count, (i + 1 > 255) ? 255 : i + 1);
        end
        do_press(1'b1);
        do_step(16'h0000);
        do_step(16'h8000);
        do_step(16'h0000);
        check("hold_done", done, 1);
        check("hold_count", run_count, 255);
        check("hold_flick_at_done", flick_out, AUTO);
        @(negedge clk);
        check("hold_done_width", done, 0);
        check("hold_flick_after", flick_out, AUTO);
        do_step(16'h0000);
        check("hold_restart_busy", busy, AUTO);
        btn_in = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
